// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder and the core's control unit:
//   - access size encodings (byte / half / word)
//   - responder FSM state encoding
//   - latched request record
//   - access-shape check (illegal size or misaligned address)
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        is_unsigned;
    } req_t;

    // 1 when the size code is illegal or the address is not naturally aligned
    // for that size. The range check lives with the RAM, which knows its depth.
    function automatic logic shape_err(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return (addr_lo != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// -----------------------------------------------------------------------------
// dmem_lane_align
// Purely combinational byte-lane steering for a little-endian 32-bit RAM.
// Ports:
//   addr_lo     in  2   byte offset within the word
//   size        in  2   access size (dmem_pkg SZ_*)
//   is_unsigned in  1   1 = zero-extend loads, 0 = sign-extend
//   wdata       in  32  right-justified store data
//   old_word    in  32  current RAM word (for the merge)
//   rd_word     in  32  RAM word being loaded
//   store_word  out 32  old_word with the addressed lanes replaced
//   byte_mask   out 4   lanes touched by a store (0 for an illegal size)
//   load_data   out 32  addressed lane(s) shifted down and extended
// -----------------------------------------------------------------------------
module dmem_lane_align (
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] old_word,
    input  logic [31:0] rd_word,
    output logic [31:0] store_word,
    output logic [3:0]  byte_mask,
    output logic [31:0] load_data
);
    import dmem_pkg::*;

    logic [31:0] wdata_rep;
    logic [31:0] shifted;

    // Replicating the store data across the word puts the right bytes on every
    // lane the mask can select, so no per-lane shifter is needed.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        byte_mask = 4'b0000;
        wdata_rep = wdata;
        case (size)
            SZ_BYTE: begin
                byte_mask = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                byte_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            SZ_WORD: begin
                byte_mask = 4'b1111;
            end
            default: ;
        endcase

        store_word = old_word;
        for (int b = 0; b < 4; b++) begin
            if (byte_mask[b]) begin
                store_word[8*b +: 8] = wdata_rep[8*b +: 8];
            end
        end
    end

    always_comb begin
        shifted   = rd_word >> {addr_lo, 3'b000};
        load_data = rd_word;
        case (size)
            SZ_BYTE: load_data = is_unsigned ? {24'h0, shifted[7:0]}
                                             : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_data = is_unsigned ? {16'h0, shifted[15:0]}
                                             : {{16{shifted[15]}}, shifted[15:0]};
            default: load_data = rd_word;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Target-side data memory for the core's load/store port. Accepts one request
// at a time, waits LATENCY cycles, performs the access on an internal RAM and
// returns a response that is held until the core takes it.
// Parameters:
//   DEPTH_WORDS  number of 32-bit words; legal byte addresses 0..4*DEPTH_WORDS-1
//   LATENCY      wait-state cycles between accept and response (0..15)
// Ports:
//   clk           in  1   rising-edge clock
//   rst           in  1   synchronous active-high reset
//   req_valid     in  1   request present
//   req_ready     out 1   responder can accept a request
//   req_we        in  1   1 = store, 0 = load
//   req_addr      in  32  byte address
//   req_wdata     in  32  right-justified store data
//   req_size      in  2   00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned  in  1   1 = zero-extend load
//   rsp_valid     out 1   response present
//   rsp_ready     in  1   core accepts response
//   rsp_rdata     out 32  extended load data; 0 for stores and errors
//   rsp_err       out 1   misaligned, illegal size or out of range
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    import dmem_pkg::*;

    localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] LAT_INIT = 4'(LATENCY);

    state_t           state;
    state_t           state_nxt;
    req_t             in_req;
    req_t             lat_req;
    req_t             cur;
    logic [3:0]       cnt;
    logic             accept;
    logic             access;
    logic             err;
    logic [IDX_W-1:0] idx;
    logic [31:0]      mem_word;
    logic [31:0]      store_word;
    logic [3:0]       byte_mask;
    logic [31:0]      load_data;

    logic [31:0] mem [DEPTH_WORDS];

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values regardless of process order.
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = (LATENCY == 0) ? S_RESP : S_WAIT;
            S_WAIT:  if (cnt == 4'd1) state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // req_ready is gated by rst so nothing can be accepted in a reset cycle.
    always_comb begin
        req_ready = (state == S_IDLE) && !rst;
        rsp_valid = (state == S_RESP);
    end

    // ------------------------------------------------------------ request path
    always_comb begin
        in_req.we          = req_we;
        in_req.addr        = req_addr;
        in_req.wdata       = req_wdata;
        in_req.size        = req_size;
        in_req.is_unsigned = req_unsigned;
    end

    assign accept = req_valid && req_ready;

    // With zero wait states the access happens on the accept edge itself, so
    // the incoming request is used directly instead of the latched copy.
    assign cur = (state == S_IDLE) ? in_req : lat_req;

    assign access = !rst && (((state == S_IDLE) && accept && (LATENCY == 0)) ||
                             ((state == S_WAIT) && (cnt == 4'd1)));

    assign err = shape_err(cur.size, cur.addr[1:0]) ||
                 ({2'b00, cur.addr[31:2]} >= 32'(DEPTH_WORDS));

    assign idx      = cur.addr[IDX_W+1:2];
    assign mem_word = mem[idx];

    dmem_lane_align u_lane_align (
        .addr_lo     (cur.addr[1:0]),
        .size        (cur.size),
        .is_unsigned (cur.is_unsigned),
        .wdata       (cur.wdata),
        .old_word    (mem_word),
        .rd_word     (mem_word),
        .store_word  (store_word),
        .byte_mask   (byte_mask),
        .load_data   (load_data)
    );

    // ---------------------------------------------- latch, counter, response
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_req   <= '0;
            cnt       <= 4'd0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                lat_req <= in_req;
                cnt     <= LAT_INIT;
            end else if (state == S_WAIT) begin
                cnt <= cnt - 4'd1;
            end

            if (access) begin
                rsp_err   <= err;
                rsp_rdata <= (err || cur.we) ? 32'h0 : load_data;
            end
        end
    end

    // ---------------------------------------------------------------- RAM
    // NOTE: the RAM array has no reset so it maps onto block RAM; only control state is reset.
    always_ff @(posedge clk) begin
        if (access && cur.we && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_mask[b]) begin
                    mem[idx][8*b +: 8] <= store_word[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Three responders (LATENCY 2, 0 and 4) share one clock. Drivers issue requests
// and push the expected response, computed from a byte-addressed reference
// memory, into a per-instance queue; a monitor pops and compares whenever a
// response is presented and also checks the response latency.
// -----------------------------------------------------------------------------
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int DEPTH  = 64;
    localparam int NBYTES = 4 * DEPTH;
    localparam int NI     = 3;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst          [NI];
    logic        req_valid    [NI];
    logic        req_ready    [NI];
    logic        req_we       [NI];
    logic [31:0] req_addr     [NI];
    logic [31:0] req_wdata    [NI];
    logic [1:0]  req_size     [NI];
    logic        req_unsigned [NI];
    logic        rsp_valid    [NI];
    logic        rsp_ready    [NI];
    logic [31:0] rsp_rdata    [NI];
    logic        rsp_err      [NI];

    int          bp_mode  [NI];   // 0: always ready, 1: random, 2: stalled
    logic [7:0]  byte_mem [NI][NBYTES];
    exp_t        exp_q    [NI][$];
    logic        seen     [NI];
    int unsigned cyc = 0;
    int          checks   = 0;
    int          failures = 0;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        dmem_responder #(
            .DEPTH_WORDS (DEPTH),
            .LATENCY     (gi == 0 ? 2 : (gi == 1 ? 0 : 4))
        ) u_dut (
            .clk          (clk),
            .rst          (rst[gi]),
            .req_valid    (req_valid[gi]),
            .req_ready    (req_ready[gi]),
            .req_we       (req_we[gi]),
            .req_addr     (req_addr[gi]),
            .req_wdata    (req_wdata[gi]),
            .req_size     (req_size[gi]),
            .req_unsigned (req_unsigned[gi]),
            .rsp_valid    (rsp_valid[gi]),
            .rsp_ready    (rsp_ready[gi]),
            .rsp_rdata    (rsp_rdata[gi]),
            .rsp_err      (rsp_err[gi])
        );
    end

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 0 : 4);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%08h required=0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference behaviour on a byte-addressed memory.
    function automatic void model_access(input int k, input logic we, input logic [31:0] addr,
                                         input logic [31:0] wdata, input logic [1:0] size,
                                         input logic uns, output logic [31:0] rdata,
                                         output logic err);
        int          nb;
        logic [31:0] val;
        err = 1'b0;
        if (size == 2'd3) err = 1'b1;
        else if (size == 2'd1 && (addr % 2) != 0) err = 1'b1;
        else if (size == 2'd2 && (addr % 4) != 0) err = 1'b1;
        if (addr >= 32'(NBYTES)) err = 1'b1;
        rdata = 32'h0;
        if (err) return;
        nb = 1 << size;
        if (we) begin
            for (int i = 0; i < nb; i++) byte_mem[k][int'(addr) + i] = wdata[8*i +: 8];
        end else begin
            val = 32'h0;
            for (int i = 0; i < nb; i++) val = val | (32'(byte_mem[k][int'(addr) + i]) << (8 * i));
            if (!uns && nb < 4 && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8 * nb));
            rdata = val;
        end
    endfunction

    // Response-ready generator; all rsp_ready changes happen 1 time unit after posedge.
    always begin
        @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            case (bp_mode[k])
                1:       rsp_ready[k] = ($urandom % 3) != 0;
                2:       rsp_ready[k] = 1'b0;
                default: rsp_ready[k] = 1'b1;
            endcase
        end
    end

    // Monitor: latency on first sight of a response, data every cycle it is
    // presented (covers stability under stall), pop on handshake.
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (rst[k] === 1'b1) begin
                seen[k] = 1'b0;
            end else if (rsp_valid[k] === 1'b1) begin
                if (exp_q[k].size() == 0) begin
                    check($sformatf("unexpected_rsp[%0d]", k), 32'd1, 32'd0);
                end else begin
                    if (!seen[k]) begin
                        seen[k] = 1'b1;
                        check($sformatf("latency[%0d]", k), cyc, exp_q[k][0].acc + lat_of(k));
                    end
                    check($sformatf("rdata[%0d]", k), rsp_rdata[k], exp_q[k][0].rdata);
                    check($sformatf("err[%0d]", k), {31'h0, rsp_err[k]}, {31'h0, exp_q[k][0].err});
                    if (rsp_ready[k] === 1'b1) begin
                        void'(exp_q[k].pop_front());
                        seen[k] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic do_req(input int k, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                          input bit track, output int unsigned acc);
        bit          got;
        exp_t        e;
        @(posedge clk);
        #1;
        req_valid[k]    = 1'b1;
        req_we[k]       = we;
        req_addr[k]     = addr;
        req_wdata[k]    = wdata;
        req_size[k]     = size;
        req_unsigned[k] = uns;
        got = 1'b0;
        for (int t = 0; t < 300 && !got; t++) begin
            @(negedge clk);
            if (req_ready[k] === 1'b1) got = 1'b1;
        end
        acc = cyc + 1;
        if (!got) begin
            check($sformatf("accept_timeout[%0d]", k), 32'd0, 32'd1);
            req_valid[k] = 1'b0;
            return;
        end
        if (track) begin
            model_access(k, we, addr, wdata, size, uns, e.rdata, e.err);
            e.acc = acc;
            exp_q[k].push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        bit done;
        done = 1'b0;
        for (int t = 0; t < 500 && !done; t++) begin
            @(negedge clk);
            if (exp_q[k].size() == 0) done = 1'b1;
        end
        check($sformatf("drain[%0d]", k), {31'h0, done}, 32'd1);
    endtask

    task automatic init_mem(input int k);
        int unsigned acc;
        for (int w = 0; w < DEPTH; w++) do_req(k, 1'b1, 32'(4 * w), $urandom, SZ_WORD, 1'b0, 1'b1, acc);
        wait_idle(k);
    endtask

    task automatic rand_traffic(input int k, input int n);
        int unsigned acc;
        logic [31:0] addr;
        logic [1:0]  size;
        int          r;
        for (int i = 0; i < n; i++) begin
            size = ($urandom % 12 == 0) ? 2'd3 : 2'($urandom % 3);
            r = $urandom % 10;
            if (r == 0)      addr = 32'($urandom_range(NBYTES, NBYTES + 63));
            else if (r == 1) addr = $urandom;
            else             addr = 32'($urandom_range(0, NBYTES - 1));
            if (r > 2 && size != 2'd3) addr = addr & ~((32'd1 << size) - 32'd1);
            do_req(k, 1'($urandom), addr, $urandom, size, 1'($urandom), 1'b1, acc);
        end
        wait_idle(k);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int unsigned acc;
        int unsigned acc2;
        bit          got;

        for (int k = 0; k < NI; k++) begin
            rst[k] = 1'b1;  req_valid[k] = 1'b0; req_we[k] = 1'b0;
            req_addr[k] = '0; req_wdata[k] = '0; req_size[k] = SZ_WORD;
            req_unsigned[k] = 1'b0; rsp_ready[k] = 1'b1; bp_mode[k] = 0; seen[k] = 1'b0;
        end

        // ---- reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("rst_req_ready[%0d]", k), {31'h0, req_ready[k]}, 32'd0);
            check($sformatf("rst_rsp_valid[%0d]", k), {31'h0, rsp_valid[k]}, 32'd0);
            check($sformatf("rst_rsp_rdata[%0d]", k), rsp_rdata[k], 32'h0);
            check($sformatf("rst_rsp_err[%0d]", k), {31'h0, rsp_err[k]}, 32'd0);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) rst[k] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < NI; k++)
            check($sformatf("post_rst_req_ready[%0d]", k), {31'h0, req_ready[k]}, 32'd1);

        // ---- fill every RAM so all later loads are defined
        fork
            init_mem(0);
            init_mem(1);
            init_mem(2);
        join

        // ---- word round trip, merge/extension, errors (LATENCY=2)
        do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, SZ_WORD, 1'b0, 1'b1, acc);
        do_req(0, 1'b0, 32'h10, 32'h0,       SZ_WORD, 1'b0, 1'b1, acc);
        do_req(0, 1'b1, 32'h20, 32'h11223344, SZ_WORD, 1'b0, 1'b1, acc);
        do_req(0, 1'b1, 32'h21, 32'h000000A5, SZ_BYTE, 1'b0, 1'b1, acc);
        do_req(0, 1'b0, 32'h20, 32'h0, SZ_WORD, 1'b0, 1'b1, acc);
        do_req(0, 1'b0, 32'h21, 32'h0, SZ_BYTE, 1'b0, 1'b1, acc);
        do_req(0, 1'b0, 32'h21, 32'h0, SZ_BYTE, 1'b1, 1'b1, acc);
        do_req(0, 1'b0, 32'h22, 32'h0, SZ_HALF, 1'b0, 1'b1, acc);
        do_req(0, 1'b0, 32'h22, 32'h0, SZ_HALF, 1'b1, 1'b1, acc);
        do_req(0, 1'b1, 32'h22, 32'hFFFFFFFF, SZ_WORD, 1'b0, 1'b1, acc);
        do_req(0, 1'b0, 32'h20, 32'h0, SZ_WORD, 1'b0, 1'b1, acc);
        do_req(0, 1'b0, 32'h23, 32'h0, SZ_HALF, 1'b0, 1'b1, acc);
        do_req(0, 1'b0, 32'(NBYTES), 32'h0, SZ_WORD, 1'b0, 1'b1, acc);
        do_req(0, 1'b0, 32'h24, 32'h0, 2'b11, 1'b0, 1'b1, acc);
        do_req(0, 1'b1, 32'(NBYTES - 2), 32'h0000BEEF, SZ_HALF, 1'b0, 1'b1, acc);
        do_req(0, 1'b0, 32'(NBYTES - 4), 32'h0, SZ_WORD, 1'b0, 1'b1, acc);
        wait_idle(0);

        // ---- backpressure: response held 5+ cycles, competing request waits
        bp_mode[0] = 2;
        do_req(0, 1'b0, 32'h20, 32'h0, SZ_WORD, 1'b0, 1'b1, acc);
        got = 1'b0;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            if (rsp_valid[0] === 1'b1) got = 1'b1;
        end
        check("bp_rsp_timeout", {31'h0, got}, 32'd1);
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h30;
        req_wdata[0] = 32'h5A5A1234; req_size[0] = SZ_WORD; req_unsigned[0] = 1'b0;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            check("bp_req_ready_low", {31'h0, req_ready[0]}, 32'd0);
            check("bp_rsp_valid_high", {31'h0, rsp_valid[0]}, 32'd1);
        end
        bp_mode[0] = 0;
        @(negedge clk);
        check("bp_req_ready_at_handshake", {31'h0, req_ready[0]}, 32'd0);
        @(negedge clk);
        check("bp_req_ready_after", {31'h0, req_ready[0]}, 32'd1);
        begin
            exp_t e;
            model_access(0, 1'b1, 32'h30, 32'h5A5A1234, SZ_WORD, 1'b0, e.rdata, e.err);
            e.acc = cyc + 1;
            exp_q[0].push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        do_req(0, 1'b0, 32'h30, 32'h0, SZ_WORD, 1'b0, 1'b1, acc);
        wait_idle(0);

        // ---- reset while a store waits (LATENCY=4)
        do_req(2, 1'b1, 32'h0, 32'h0, SZ_WORD, 1'b0, 1'b1, acc);
        wait_idle(2);
        do_req(2, 1'b1, 32'h0, 32'hCAFEF00D, SZ_WORD, 1'b0, 1'b0, acc);
        @(posedge clk);
        #1;
        rst[2] = 1'b1;
        @(negedge clk);
        check("midrst_req_ready_in_rst", {31'h0, req_ready[2]}, 32'd0);
        check("midrst_rsp_valid_in_rst", {31'h0, rsp_valid[2]}, 32'd0);
        @(posedge clk);
        #1;
        rst[2] = 1'b0;
        @(negedge clk);
        check("midrst_req_ready_after", {31'h0, req_ready[2]}, 32'd1);
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            check("midrst_no_rsp", {31'h0, rsp_valid[2]}, 32'd0);
        end
        do_req(2, 1'b0, 32'h0, 32'h0, SZ_WORD, 1'b0, 1'b1, acc);
        wait_idle(2);

        // ---- zero wait states: one transaction per two cycles
        do_req(1, 1'b1, 32'h8, 32'h89ABCDEF, SZ_WORD, 1'b0, 1'b1, acc);
        do_req(1, 1'b0, 32'h8, 32'h0, SZ_WORD, 1'b0, 1'b1, acc2);
        check("lat0_throughput", acc2 - acc, 32'd2);
        wait_idle(1);

        // ---- randomized traffic with random response backpressure
        for (int k = 0; k < NI; k++) bp_mode[k] = 1;
        fork
            rand_traffic(0, 150);
            rand_traffic(1, 150);
            rand_traffic(2, 150);
        join
        for (int k = 0; k < NI; k++) bp_mode[k] = 0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++)
            check($sformatf("final_queue_empty[%0d]", k), exp_q[k].size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder (target side) for the core's load/store port.
- Accepts one request at a time over a valid/ready handshake and waits a configurable number of wait states.
- Performs byte/half/word stores with lane merge, and loads with lane extraction and sign/zero extension.
- Returns a response over a valid/ready handshake, flagging misaligned or out-of-range accesses.
- Sits between the core's MEM stage and on-chip data RAM; lets the core be tested against non-zero memory latency.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the RAM; legal byte addresses are 0 .. 4*DEPTH_WORDS-1.
- LATENCY, 2, wait-state cycles between request accept and response (0..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  1 = zero-extend load, 0 = sign-extend.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned, illegal size, or out of range.

Behaviour:
- Reset: sync, active-high; rst wins over all other inputs in the same cycle.
  - On reset: state=IDLE, req_ready=0 during the rst cycle and 1 from the first cycle after; rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
  - RAM contents are not cleared by reset.
- FSM states IDLE, WAIT, RESP:
  - IDLE: req_ready=1. On req_valid & req_ready at edge N, latch we/addr/wdata/size/unsigned and load counter=LATENCY. Go to WAIT if LATENCY>0, else go to RESP (access performed at that edge).
  - WAIT: req_ready=0; counter decrements each cycle. When counter==1, perform the access at that edge and go to RESP.
  - RESP: rsp_valid=1, rdata/err held stable, req_ready=0. Return to IDLE on rsp_ready. Holds indefinitely while rsp_ready=0.
- Latency: accept at edge N gives rsp_valid=1 in the cycle after edge N+LATENCY. Minimum back-to-back throughput is one request per LATENCY+2 cycles.
- Error check, done on the latched request:
  - size 11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr[31:2] >= DEPTH_WORDS.
  - On error: no RAM write, rsp_err=1, rsp_rdata=0.
- Store: only addressed lanes written.
  - Byte: wdata[7:0] goes to lane addr[1:0].
  - Half: wdata[15:0] goes to lanes {addr[1],0}..+1.
  - Word: all four lanes.
  - Other bytes in the word are unchanged.
  - rsp_rdata=0.
- Load: read word addr[31:2], extract lane, then extend. Byte from bit 7 if signed, else zero; half from bit 15. Word is passed through; req_unsigned is ignored for word loads.
- Little-endian.
- Reset mid-operation: a store latched but still in WAIT when rst asserts is dropped (RAM not modified). A store already committed is not undone.
- req_valid while not in IDLE is ignored; the request is not accepted and the core must hold it.
- Loads of untouched RAM return unspecified data; the bench must initialise before reading.

Decomposition:
- Shared package dmem_pkg:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - FSM state encodings S_IDLE, S_WAIT, S_RESP.
  - Reused by the core's control unit for its width/sign signals.
- One combinational sub-module, dmem_lane_align:
  - inputs addr[1:0], size, unsigned, wdata, old word, read word;
  - outputs merged store word, byte-lane write mask, extended load data.
- The FSM, counter, error check and RAM array stay in dmem_responder.

Test Plan:
- Word round trip (LATENCY=2): store 0xDEADBEEF @0x10, then load word @0x10 → rsp_valid exactly 3 cycles after each accept; load returns 0xDEADBEEF, err=0.
- Byte/half merge and extension: word 0x11223344 @0x20; store byte 0xA5 @0x21 → word reads 0x1122A544. Signed byte load @0x21 → 0xFFFFFFA5; unsigned → 0x000000A5. Signed half load @0x22 → 0x00001122.
- Errors: word store @0x22 → err=1, rdata=0, word @0x20 unchanged. Half load @0x23 → err=1. Word load @4*DEPTH_WORDS → err=1. Size 11 → err=1.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP → rsp_valid, rdata and err stable; req_ready=0 throughout; a new req_valid is not accepted until the cycle after the rsp_ready handshake.
- Reset mid-op: word 0 = 0x0; store 0xCAFEF00D @0x0 with LATENCY=4; assert rst 2 cycles after accept → rsp_valid never rises; after reset, load @0x0 returns 0x00000000; req_ready=1 the cycle after rst deasserts.
- LATENCY=0: store then load @0x8 with rsp_ready tied 1 → rsp_valid the cycle after each accept; one transaction per 2 cycles.
